// File: rtl/mult_unit_pkg.sv
// Shared definitions for the multiply unit: unit codes, funct code, pipeline slot
// layout and the arithmetic helpers used between slots.
package mult_unit_pkg;

    typedef enum logic [1:0] {
        FU_ALU  = 2'b00,
        FU_MEM  = 2'b01,
        FU_MUL  = 2'b10,
        FU_NONE = 2'b11
    } fu_code_e;

    localparam logic [5:0] FUNCT_MULT     = 6'b011000;
    localparam int         DEFAULT_STAGES = 4;

    // data holds {rega, regb} before the multiply slot and the 64-bit product after it
    typedef struct packed {
        logic        valid;
        logic        unsig;
        logic [4:0]  regdest;
        logic        writereg;
        logic        writeov;
        logic        oflow;
        logic [63:0] data;
    } slot_t;

    function automatic logic [63:0] mul64(input logic [31:0] a, input logic [31:0] b,
                                          input logic unsig);
        logic [63:0] ea;
        logic [63:0] eb;
        ea = {{32{~unsig & a[31]}}, a};
        eb = {{32{~unsig & b[31]}}, b};
        return ea * eb;
    endfunction

    function automatic logic overflow64(input logic [63:0] p, input logic unsig);
        if (unsig)
            return |p[63:32];
        return p[63:32] != {32{p[31]}};
    endfunction

    // Work done on the way into a slot: multiply entering slot 1, flags entering the last slot
    function automatic slot_t stage_step(input slot_t s, input logic do_mul, input logic do_final);
        slot_t r;
        r = s;
        if (do_mul)
            r.data = mul64(s.data[63:32], s.data[31:0], s.unsig);
        if (do_final) begin
            r.oflow    = s.writeov & overflow64(r.data, s.unsig);
            r.writereg = s.writereg & ~r.oflow & (s.regdest != 5'd0);
        end
        return r;
    endfunction

endpackage

// File: rtl/mult_unit_if.sv
// Issue and writeback signals of the multiply unit; slave is the unit side.
interface mult_unit_if;
    import mult_unit_pkg::*;

    logic        iss_mul_oper;
    logic [31:0] iss_ex_rega;
    logic [31:0] iss_ex_regb;
    logic        iss_ex_unsig;
    logic [4:0]  iss_ex_regdest;
    logic        iss_ex_writereg;
    logic        iss_ex_writeov;
    logic        mul_iss_ready;
    logic        mul_wb_valid;
    logic [4:0]  mul_wb_regdest;
    logic [31:0] mul_wb_data;
    logic        mul_wb_writereg;
    logic        mul_wb_oflow;
    logic        wb_mul_grant;

    modport master (
        output iss_mul_oper, iss_ex_rega, iss_ex_regb, iss_ex_unsig,
               iss_ex_regdest, iss_ex_writereg, iss_ex_writeov, wb_mul_grant,
        input  mul_iss_ready, mul_wb_valid, mul_wb_regdest, mul_wb_data,
               mul_wb_writereg, mul_wb_oflow
    );

    modport slave (
        input  iss_mul_oper, iss_ex_rega, iss_ex_regb, iss_ex_unsig,
               iss_ex_regdest, iss_ex_writereg, iss_ex_writeov, wb_mul_grant,
        output mul_iss_ready, mul_wb_valid, mul_wb_regdest, mul_wb_data,
               mul_wb_writereg, mul_wb_oflow
    );

endinterface

// File: rtl/mult_stage.sv
// One pipeline slot of the multiply unit: a register that keeps its contents while hold_i.
module mult_stage
    import mult_unit_pkg::*;
(
    input  logic  clock,
    input  logic  reset,
    input  logic  hold_i,
    input  slot_t d_i,
    output slot_t q_o
);

    slot_t slot_q;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset)
            slot_q <= '0;
        else if (!hold_i)
            slot_q <= d_i;
    end

    assign q_o = slot_q;

endmodule

// File: rtl/mult_unit.sv
// Pipelined 32x32 multiplier with a fixed STAGES-cycle latency; the whole pipe
// freezes while the writeback slot is occupied and not granted.
module mult_unit
    import mult_unit_pkg::*;
#(
    parameter int STAGES = DEFAULT_STAGES
) (
    input logic       clock,
    input logic       reset,
    mult_unit_if.slave bus
);

    slot_t slot_q [STAGES];
    logic  stall;

    assign stall             = slot_q[STAGES-1].valid & ~bus.wb_mul_grant;
    assign bus.mul_iss_ready = ~stall;

    generate
        for (genvar gi = 0; gi < STAGES; gi++) begin : g_slot
            slot_t stage_d;

            if (gi == 0) begin : g_head
                // Bubbles enter as all-zero so idle outputs stay quiet
                always_comb begin
                    stage_d = '0;
                    if (bus.iss_mul_oper) begin
                        stage_d.valid    = 1'b1;
                        stage_d.unsig    = bus.iss_ex_unsig;
                        stage_d.regdest  = bus.iss_ex_regdest;
                        stage_d.writereg = bus.iss_ex_writereg;
                        stage_d.writeov  = bus.iss_ex_writeov;
                        stage_d.data     = {bus.iss_ex_rega, bus.iss_ex_regb};
                    end
                end
            end else begin : g_body
                always_comb begin
                    stage_d = stage_step(slot_q[gi-1], gi == 1, gi == STAGES - 1);
                end
            end

            mult_stage u_stage (
                .clock  (clock),
                .reset  (reset),
                .hold_i (stall),
                .d_i    (stage_d),
                .q_o    (slot_q[gi])
            );
        end
    endgenerate

    assign bus.mul_wb_valid    = slot_q[STAGES-1].valid;
    assign bus.mul_wb_regdest  = slot_q[STAGES-1].regdest;
    assign bus.mul_wb_data     = slot_q[STAGES-1].data[31:0];
    assign bus.mul_wb_writereg = slot_q[STAGES-1].writereg;
    assign bus.mul_wb_oflow    = slot_q[STAGES-1].oflow;

endmodule
